// File: rtl/axis_stream_monitor.sv
// Passive multi-channel AXI-Stream handshake monitor: saturating per-channel counters with snapshot/clear.
// Latency: events land in live counters at the sampling edge; rd_data is registered one clock behind ctrl/counters.
// Backpressure: none; observes tvalid/tready/tlast only and never drives or delays the monitored streams.
module axis_stream_monitor #(
    parameter int NUM_CH    = 3,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 c0_ddr4_clk,
    input  logic                 c0_ddr4_rst,
    input  logic [NUM_CH-1:0]    ch_tvalid,
    input  logic [NUM_CH-1:0]    ch_tready,
    input  logic [NUM_CH-1:0]    ch_tlast,
    input  logic [31:0]          ctrl,
    output logic [31:0]          rd_data,
    output logic [31:0]          status
);

    localparam int NSEL   = 5;
    localparam int BEAT   = 0;
    localparam int STALL  = 1;
    localparam int STARVE = 2;
    localparam int PKT    = 3;
    localparam int MAXS   = 4;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] live_q   [NUM_CH][NSEL];
    logic [CNT_WIDTH-1:0] shadow_q [NUM_CH][NSEL];
    logic [CNT_WIDTH-1:0] run_q    [NUM_CH];
    logic [CNT_WIDTH-1:0] run_inc  [NUM_CH];
    logic [NUM_CH-1:0]    sticky_q;
    logic [NUM_CH-1:0]    stall_now_q;
    logic [NUM_CH-1:0]    sat_hit;
    logic [15:0]          seq_q;
    logic                 clr_q;
    logic                 snap_q;

    logic [2:0]           ch_sel;
    logic [2:0]           cnt_sel;
    logic                 live_mode;
    logic                 clr_edge;
    logic                 snap_edge;
    logic                 unused_ctrl;

    logic [NUM_CH-1:0]    beat;
    logic [NUM_CH-1:0]    stall;
    logic [NUM_CH-1:0]    starve;
    logic [NUM_CH-1:0]    pkt;

    logic [CNT_WIDTH-1:0] sel_val;
    logic [31:0]          rd_next;
    logic [7:0]           sticky_b;
    logic [7:0]           stall_b;

    assign ch_sel      = ctrl[2:0];
    assign cnt_sel     = ctrl[5:3];
    assign live_mode   = ctrl[10];
    assign clr_edge    = ctrl[8] & ~clr_q;
    assign snap_edge   = ctrl[9] & ~snap_q;
    assign unused_ctrl = ^{ctrl[31:11], ctrl[7:6]};

    assign beat   = ch_tvalid & ch_tready;
    assign stall  = ch_tvalid & ~ch_tready;
    assign starve = ch_tready & ~ch_tvalid;
    assign pkt    = ch_tvalid & ch_tready & ch_tlast;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        sat_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            run_inc[i] = sat_inc(run_q[i]);
            sat_hit[i] = (beat[i]   && live_q[i][BEAT]   == CNT_MAX) ||
                         (stall[i]  && live_q[i][STALL]  == CNT_MAX) ||
                         (starve[i] && live_q[i][STARVE] == CNT_MAX) ||
                         (pkt[i]    && live_q[i][PKT]    == CNT_MAX);
        end
    end

    always_ff @(posedge c0_ddr4_clk or posedge c0_ddr4_rst) begin
        if (c0_ddr4_rst) begin
            clr_q       <= 1'b0;
            snap_q      <= 1'b0;
            seq_q       <= '0;
            sticky_q    <= '0;
            stall_now_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                run_q[i] <= '0;
                for (int k = 0; k < NSEL; k++) begin
                    live_q[i][k]   <= '0;
                    shadow_q[i][k] <= '0;
                end
            end
        end else begin
            clr_q  <= ctrl[8];
            snap_q <= ctrl[9];
            if (snap_edge) seq_q <= seq_q + 16'd1;
            for (int i = 0; i < NUM_CH; i++) begin
                stall_now_q[i] <= stall[i];
                // Shadows take the values as of the start of the cycle, before any clear.
                if (snap_edge) begin
                    for (int k = 0; k < NSEL; k++) shadow_q[i][k] <= live_q[i][k];
                end
                if (clr_edge) begin
                    for (int k = 0; k < NSEL; k++) live_q[i][k] <= '0;
                    run_q[i]    <= '0;
                    sticky_q[i] <= 1'b0;
                end else begin
                    if (beat[i])   live_q[i][BEAT]   <= sat_inc(live_q[i][BEAT]);
                    if (stall[i])  live_q[i][STALL]  <= sat_inc(live_q[i][STALL]);
                    if (starve[i]) live_q[i][STARVE] <= sat_inc(live_q[i][STARVE]);
                    if (pkt[i])    live_q[i][PKT]    <= sat_inc(live_q[i][PKT]);
                    run_q[i] <= stall[i] ? run_inc[i] : '0;
                    if (stall[i] && run_inc[i] > live_q[i][MAXS]) live_q[i][MAXS] <= run_inc[i];
                    if (sat_hit[i]) sticky_q[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == i[2:0]) begin
                for (int k = 0; k < NSEL; k++) begin
                    if (cnt_sel == k[2:0]) sel_val = live_mode ? live_q[i][k] : shadow_q[i][k];
                end
            end
        end
        rd_next = '0;
        rd_next[CNT_WIDTH-1:0] = sel_val;
    end

    always_ff @(posedge c0_ddr4_clk or posedge c0_ddr4_rst) begin
        if (c0_ddr4_rst) rd_data <= '0;
        else             rd_data <= rd_next;
    end

    always_comb begin
        sticky_b = '0;
        stall_b  = '0;
        sticky_b[NUM_CH-1:0] = sticky_q;
        stall_b[NUM_CH-1:0]  = stall_now_q;
    end

    assign status = {seq_q, stall_b, sticky_b};

endmodule

// File: tb/tb_axis_stream_monitor.sv
// Directed bench for axis_stream_monitor (NUM_CH=3, CNT_WIDTH=8): table-driven readback plus corner sequences.
module tb_axis_stream_monitor;

    logic        c0_ddr4_clk;
    logic        c0_ddr4_rst;
    logic [2:0]  ch_tvalid;
    logic [2:0]  ch_tready;
    logic [2:0]  ch_tlast;
    logic [31:0] ctrl;
    logic [31:0] rd_data;
    logic [31:0] status;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  ch;
        logic [2:0]  sel;
        logic        live;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    axis_stream_monitor #(.NUM_CH(3), .CNT_WIDTH(8)) dut (
        .c0_ddr4_clk (c0_ddr4_clk),
        .c0_ddr4_rst (c0_ddr4_rst),
        .ch_tvalid   (ch_tvalid),
        .ch_tready   (ch_tready),
        .ch_tlast    (ch_tlast),
        .ctrl        (ctrl),
        .rd_data     (rd_data),
        .status      (status)
    );

    initial c0_ddr4_clk = 1'b0;
    always #5 c0_ddr4_clk = ~c0_ddr4_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge c0_ddr4_clk);
        @(negedge c0_ddr4_clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic set_rd(input logic [2:0] ch, input logic [2:0] sel, input logic live);
        ctrl       = '0;
        ctrl[2:0]  = ch;
        ctrl[5:3]  = sel;
        ctrl[10]   = live;
    endtask

    task automatic rd(input logic [2:0] ch, input logic [2:0] sel, input logic live);
        set_rd(ch, sel, live);
        cyc();
    endtask

    task automatic idle();
        ch_tvalid = '0;
        ch_tready = '0;
        ch_tlast  = '0;
    endtask

    task automatic stall_run(input int n);
        for (int k = 0; k < n; k++) begin
            ch_tvalid[1] = 1'b1;
            ch_tready[1] = 1'b0;
            cyc();
            check("stall_now_ch1", {24'd0, status[15:8]}, 32'h02);
        end
    endtask

    initial begin
        vecs[0]  = '{ch: 3'd0, sel: 3'd0, live: 1'b0, exp: 32'd10};
        vecs[1]  = '{ch: 3'd0, sel: 3'd3, live: 1'b0, exp: 32'd2};
        vecs[2]  = '{ch: 3'd0, sel: 3'd1, live: 1'b0, exp: 32'd0};
        vecs[3]  = '{ch: 3'd1, sel: 3'd1, live: 1'b0, exp: 32'd10};
        vecs[4]  = '{ch: 3'd1, sel: 3'd4, live: 1'b0, exp: 32'd7};
        vecs[5]  = '{ch: 3'd1, sel: 3'd2, live: 1'b0, exp: 32'd0};
        vecs[6]  = '{ch: 3'd1, sel: 3'd0, live: 1'b0, exp: 32'd1};
        vecs[7]  = '{ch: 3'd1, sel: 3'd3, live: 1'b0, exp: 32'd0};
        vecs[8]  = '{ch: 3'd2, sel: 3'd2, live: 1'b0, exp: 32'd4};
        vecs[9]  = '{ch: 3'd2, sel: 3'd0, live: 1'b0, exp: 32'd0};
        vecs[10] = '{ch: 3'd0, sel: 3'd0, live: 1'b1, exp: 32'd10};
        vecs[11] = '{ch: 3'd5, sel: 3'd0, live: 1'b1, exp: 32'd0};
        vecs[12] = '{ch: 3'd1, sel: 3'd1, live: 1'b1, exp: 32'd10};
        vecs[13] = '{ch: 3'd5, sel: 3'd1, live: 1'b1, exp: 32'd0};
        vecs[14] = '{ch: 3'd1, sel: 3'd4, live: 1'b1, exp: 32'd7};
        vecs[15] = '{ch: 3'd1, sel: 3'd6, live: 1'b1, exp: 32'd0};
        vecs[16] = '{ch: 3'd0, sel: 3'd3, live: 1'b1, exp: 32'd2};
        vecs[17] = '{ch: 3'd0, sel: 3'd5, live: 1'b1, exp: 32'd0};

        // Reset state
        c0_ddr4_rst = 1'b1;
        ctrl = '0;
        idle();
        #2;
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_status", status, 32'd0);
        @(negedge c0_ddr4_clk);
        c0_ddr4_rst = 1'b0;

        // Beats and packets on ch0, tlast on cycles 5 and 10
        for (int k = 1; k <= 10; k++) begin
            ch_tvalid[0] = 1'b1;
            ch_tready[0] = 1'b1;
            ch_tlast[0]  = (k == 5 || k == 10);
            cyc();
        end
        idle();
        ctrl = '0;
        ctrl[9] = 1'b1;
        cyc();
        check("seq_after_snap1", {16'd0, status[31:16]}, 32'd1);
        ctrl = '0;

        // Stall runs on ch1: 3, idle, 7, then a beat
        stall_run(3);
        idle();
        cyc();
        check("stall_now_after_idle", {24'd0, status[15:8]}, 32'h00);
        stall_run(7);
        ch_tvalid[1] = 1'b1;
        ch_tready[1] = 1'b1;
        cyc();
        check("stall_now_after_beat", {24'd0, status[15:8]}, 32'h00);
        idle();

        // Starvation on ch2 for 4 cycles
        for (int k = 0; k < 4; k++) begin
            ch_tready[2] = 1'b1;
            cyc();
        end
        idle();
        ctrl = '0;
        ctrl[9] = 1'b1;
        cyc();
        check("seq_after_snap2", {16'd0, status[31:16]}, 32'd2);
        check("sticky_none", {24'd0, status[7:0]}, 32'd0);

        for (int v = 0; v < 18; v++) begin
            rd(vecs[v].ch, vecs[v].sel, vecs[v].live);
            check($sformatf("vec%0d_ch%0d_sel%0d_live%0d", v, vecs[v].ch, vecs[v].sel, vecs[v].live),
                  rd_data, vecs[v].exp);
        end

        // Saturation: ch2 beat held 300 cycles with 8-bit counters
        for (int k = 0; k < 300; k++) begin
            ch_tvalid[2] = 1'b1;
            ch_tready[2] = 1'b1;
            cyc();
        end
        idle();
        rd(3'd2, 3'd0, 1'b1);
        check("sat_beat_ch2", rd_data, 32'd255);
        check("sat_sticky", {24'd0, status[7:0]}, 32'h04);

        ctrl = '0;
        ctrl[8] = 1'b1;
        cyc();
        rd(3'd2, 3'd0, 1'b1);
        check("clr_live_beat_ch2", rd_data, 32'd0);
        check("clr_sticky", {24'd0, status[7:0]}, 32'h00);
        rd(3'd1, 3'd4, 1'b1);
        check("clr_live_maxstall_ch1", rd_data, 32'd0);
        rd(3'd0, 3'd0, 1'b0);
        check("clr_keeps_shadow", rd_data, 32'd10);
        check("clr_keeps_seq", {16'd0, status[31:16]}, 32'd2);

        // Clear and snapshot in the same cycle while ch0 beats
        for (int k = 0; k < 4; k++) begin
            ch_tvalid[0] = 1'b1;
            ch_tready[0] = 1'b1;
            cyc();
        end
        ctrl = '0;
        ctrl[8] = 1'b1;
        ctrl[9] = 1'b1;
        cyc();
        idle();
        rd(3'd0, 3'd0, 1'b0);
        check("clrsnap_shadow", rd_data, 32'd4);
        rd(3'd0, 3'd0, 1'b1);
        check("clrsnap_live", rd_data, 32'd0);
        check("clrsnap_seq", {16'd0, status[31:16]}, 32'd3);

        // Level-held snapshot request acts once
        ctrl = '0;
        ctrl[9] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("held_snap_seq_c%0d", k), {16'd0, status[31:16]}, 32'd4);
        end
        ctrl = '0;
        cyc();
        check("held_snap_seq_release", {16'd0, status[31:16]}, 32'd4);

        // Asynchronous reset between edges
        set_rd(3'd0, 3'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            ch_tvalid[0] = 1'b1;
            ch_tready[0] = 1'b1;
            cyc();
        end
        check("pre_reset_rd_latency", rd_data, 32'd4);
        #2;
        c0_ddr4_rst = 1'b1;
        #1;
        check("async_rst_rd_data", rd_data, 32'd0);
        check("async_rst_status", status, 32'd0);
        @(negedge c0_ddr4_clk);
        c0_ddr4_rst = 1'b0;
        for (int k = 0; k < 3; k++) cyc();
        idle();
        cyc();
        check("resume_live_beat", rd_data, 32'd3);
        rd(3'd0, 3'd0, 1'b0);
        check("resume_shadow_zero", rd_data, 32'd0);
        check("resume_seq_zero", {16'd0, status[31:16]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_stream_monitor.md
# axis_stream_monitor

Multi-channel AXI-Stream handshake monitor for SDDT debug. It passively observes NUM_CH stream interfaces (C2H S2MM and the two H2C MM2S streams, for example) and keeps saturating per-channel counters for beats, stalls, starvation, packets and longest stall run. Snapshot and clear are commanded through the 32-bit GPIO output word. Any counter is read back through a 32-bit GPIO input word, and a status word is provided as well. It sits beside `sddt_core` in the `c0_ddr4_clk` domain.

## Interface
- `NUM_CH`, default 3: number of monitored channels, legal range 1..8.
- `CNT_WIDTH`, default 32: counter width, legal range 8..32.
- `c0_ddr4_clk`, in, 1: the single clock.
- `c0_ddr4_rst`, in, 1: asynchronous, active-high reset.
- `ch_tvalid`, in, NUM_CH: tvalid of each monitored channel. Bit i is channel i.
- `ch_tready`, in, NUM_CH: tready of each monitored channel.
- `ch_tlast`, in, NUM_CH: tlast of each monitored channel. Tie to 0 if the channel has no tlast.
- `ctrl`, in, 32: command word (`axi_gpio_out`), synchronous to `c0_ddr4_clk`.
  - [2:0] channel select.
  - [5:3] counter select.
  - [8] clear request.
  - [9] snapshot request.
  - [10] live-read mode.
- `rd_data`, out, 32: the selected counter, zero-extended from CNT_WIDTH.
- `status`, out, 32: [7:0] sticky saturation flags, [15:8] stalled-now, [31:16] snapshot sequence number. Bits at and above NUM_CH in [7:0] and [15:8] read 0.

## Operation
- Per-channel events, evaluated every cycle:
  - beat: tvalid & tready.
  - stall: tvalid & !tready.
  - starve: tready & !tvalid.
  - pkt: tvalid & tready & tlast.
- Counter select 0..4:
  - 0: beat_cnt.
  - 1: stall_cnt.
  - 2: starve_cnt.
  - 3: pkt_cnt.
  - 4: max_stall, the longest run of consecutive stall cycles.
- Select 5..7, or a channel select ≥ NUM_CH, reads 0.
- Every counter saturates at 2^CNT_WIDTH−1. It never wraps. An increment attempted while the counter is at max sets sticky `status[i]` for that channel.
- Stall run tracking: `run_i` (CNT_WIDTH, saturating) increments on a stall cycle and clears to 0 on any non-stall cycle.
  - On a stall cycle, max_stall_i ← max(max_stall_i, run_i+1), with run_i+1 saturated.
  - max_stall therefore reflects the current run in the same update.
- Clear: a rising edge of ctrl[8] (registered previous value, reset 0) zeroes all live counters, run registers and sticky flags on that clock edge.
  - Shadow registers and the sequence number are not touched.
  - Events in the clear cycle are discarded. Clear wins.
- Snapshot: a rising edge of ctrl[9] copies every live counter into its shadow register.
  - The sequence number (16-bit) increments and wraps at 0xFFFF→0x0000.
  - The copy takes the pre-update values: live values as of the start of that cycle, excluding the cycle's own events.
  - Snapshot and clear in the same cycle: shadows get the pre-clear values, then the live counters clear.
- Readback: ctrl[10]=0 reads the shadow register; ctrl[10]=1 reads the live counter.
- `status[15:8]`: registered stall event per channel.
- Level-held ctrl[8] or ctrl[9] acts once only. A new edge needs a 0 first.
- If ctrl[8] or ctrl[9] is already 1 when reset deasserts, it fires once on the first clock after release.

## Timing
- Reset values are all 0: every counter, run register, shadow register, edge register, sticky flag, the sequence number, `rd_data` and `status`.
- Counter update latency: an event at edge N is visible in the live counter after edge N. It is visible on `rd_data` (live mode) after edge N+1.
- Readback latency: `rd_data` is registered. A change of ctrl[5:0] or ctrl[10] is reflected one clock later.
- Snapshot/clear latency:
  - The ctrl[9] or ctrl[8] edge is detected at the first clock where the bit is sampled 1.
  - Shadows, or cleared counters, are updated at that clock.
  - They appear on `rd_data` one clock after that.
- Reset asserted mid-operation returns every register to its reset value immediately and asynchronously. No partial snapshot survives.
- The monitor is fully passive. It drives no handshake signal and adds no delay to the monitored streams.

## Test plan
- Beat and packet counting: ch0 valid=ready=1 for 10 cycles, with tlast on cycles 5 and 10. Then snapshot, read sel0 and sel3. Required: 10 and 2; `status[31:16]`=1.
- Stall run tracking: ch1 stalls in runs of 3, then 1 idle cycle, then 7, then a beat. Required: stall_cnt=10, max_stall=7, starve_cnt=0, `status[9]` high during the stall cycles.
- Saturation: CNT_WIDTH=8, ch2 beat held for 300 cycles. Required: beat_cnt=255 and `status[2]`=1. After a clear edge: live beat_cnt=0 and `status[2]`=0.
- Clear plus snapshot in the same cycle, while ch0 is beating. Required: shadow equals the pre-clear count; live equals 0 on the next read, with the clear-cycle beat not counted.
- Select corner cases: channel select 5 with NUM_CH=3, and counter select 6. Required: `rd_data`=0 for both. Holding ctrl[9] high for 4 cycles increments the sequence number once.
- Asynchronous reset mid-count: assert `c0_ddr4_rst` between clock edges. Required: all outputs are 0 before the next edge, and counting resumes from 0 after release.
